// File: rtl/seq_pkg.sv
// Constants shared by the static sequence generator and the serial pattern
// detector, so both ends agree on the pattern and the buzzer timing.
package seq_pkg;

  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int unsigned DEF_PATTERN_W   = 8;
  localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN = 8'b1011_1000;
  localparam int unsigned DEF_BUZZ_CYCLES = CLK_HZ;  // one second of buzz
  localparam int unsigned DEF_CNT_W       = 4;

endpackage : seq_pkg

// File: rtl/seq_pattern_detector_if.sv
// Serial-in / status-out bundle of the pattern detector. The master side is
// whoever feeds bits (generator or bench), the slave side is the detector.
interface seq_pattern_detector_if
  import seq_pkg::*;
#(
  parameter int unsigned PATTERN_W = DEF_PATTERN_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
);

  logic                 bit_in;
  logic                 bit_valid;
  logic                 clear;
  logic                 match;
  logic [CNT_W-1:0]     match_cnt;
  logic [PATTERN_W-1:0] led;
  logic                 buzzer;

  modport master (
    output bit_in, bit_valid, clear,
    input  match, match_cnt, led, buzzer
  );

  modport slave (
    input  bit_in, bit_valid, clear,
    output match, match_cnt, led, buzzer
  );

endinterface : seq_pattern_detector_if

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher: a trigger loads an N-cycle down-counter and
// the output stays high while the counter is non-zero. A trigger while the
// counter is running simply reloads it, so the output never glitches low.
module pulse_stretcher #(
  parameter int unsigned N = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic clear,
  output logic out
);

  localparam int unsigned TW = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [TW-1:0] LOAD = TW'(N);

  logic [TW-1:0] timer_p0;
  logic [TW-1:0] timer_p1;
  logic          out_p1;

  // Next timer value: clear wins, then reload, then count down to zero.
  always_comb begin
    timer_p0 = timer_p1;
    if (clear) begin
      timer_p0 = '0;
    end else if (trigger) begin
      timer_p0 = LOAD;
    end else if (timer_p1 != '0) begin
      timer_p0 = timer_p1 - TW'(1);
    end
  end

  // ---- stage p1: timer and its registered non-zero flag ----
  // Output is registered from the next timer value so it rises together with
  // the trigger's own register and is high for exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_p1 <= '0;
      out_p1   <= 1'b0;
    end else begin
      timer_p1 <= timer_p0;
      out_p1   <= (timer_p0 != '0);
    end
  end

  assign out = out_p1;

endmodule : pulse_stretcher

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector. Shifts accepted bits into a history register
// (first bit ends up in the MSB), raises a registered one-cycle match pulse
// when the last PATTERN_W bits equal PATTERN, counts matches with saturation
// and drives a retriggerable buzzer for BUZZ_CYCLES clocks per match.
module seq_pattern_detector
  import seq_pkg::*;
#(
  parameter int unsigned          PATTERN_W   = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN     = DEF_PATTERN,
  parameter int unsigned          BUZZ_CYCLES = DEF_BUZZ_CYCLES,
  parameter int unsigned          CNT_W       = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_pattern_detector_if.slave bus
);

  localparam int unsigned       FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  // Saturating increment of the match counter; holds at all-ones.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating increment of the fill level; holds once the history is full.
  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] v);
    return (v == FILL_FULL) ? v : v + FILL_W'(1);
  endfunction

  logic                 vld_p0;
  logic [PATTERN_W-1:0] hist_p0;
  logic [FILL_W-1:0]    fill_p0;
  logic                 match_p0;

  logic [PATTERN_W-1:0] hist_p1;
  logic [FILL_W-1:0]    fill_p1;
  logic                 match_p1;
  logic [CNT_W-1:0]     cnt_p1;
  logic                 buzz_p1;

  // ---- stage p0: accept the strobe and evaluate the would-be history ----
  // A clear in the same cycle drops the incoming bit entirely.
  always_comb begin
    vld_p0   = bus.bit_valid & ~bus.clear;
    hist_p0  = {hist_p1[PATTERN_W-2:0], bus.bit_in};
    fill_p0  = fill_sat_inc(fill_p1);
    match_p0 = vld_p0 && (hist_p0 == PATTERN) && (fill_p0 == FILL_FULL);
  end

  // ---- stage p1: history, fill level, match pulse and match counter ----
  // History is not cleared on a match, so overlapping occurrences are found.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_p1  <= '0;
      fill_p1  <= '0;
      match_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else if (bus.clear) begin
      hist_p1  <= '0;
      fill_p1  <= '0;
      match_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      match_p1 <= match_p0;
      if (vld_p0) begin
        hist_p1 <= hist_p0;
        fill_p1 <= fill_p0;
      end
      if (match_p0) begin
        cnt_p1 <= cnt_sat_inc(cnt_p1);
      end
    end
  end

  // The buzz timer is loaded on the same edge that registers the match.
  pulse_stretcher #(
    .N (BUZZ_CYCLES)
  ) u_buzz (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (match_p0),
    .clear   (bus.clear),
    .out     (buzz_p1)
  );

  assign bus.match     = match_p1;
  assign bus.match_cnt = cnt_p1;
  assign bus.led       = hist_p1;
  assign bus.buzzer    = buzz_p1;

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four detectors with different patterns
// share one serial stream; directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_seq_pattern_detector;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned BUZZ = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic d_bit, d_valid, d_clear;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PATTERN_W(W), .CNT_W(CW)) if_b8 ();
  seq_pattern_detector_if #(.PATTERN_W(W), .CNT_W(CW)) if_00 ();
  seq_pattern_detector_if #(.PATTERN_W(W), .CNT_W(CW)) if_aa ();
  seq_pattern_detector_if #(.PATTERN_W(W), .CNT_W(CW)) if_ff ();

  assign if_b8.bit_in = d_bit; assign if_b8.bit_valid = d_valid; assign if_b8.clear = d_clear;
  assign if_00.bit_in = d_bit; assign if_00.bit_valid = d_valid; assign if_00.clear = d_clear;
  assign if_aa.bit_in = d_bit; assign if_aa.bit_valid = d_valid; assign if_aa.clear = d_clear;
  assign if_ff.bit_in = d_bit; assign if_ff.bit_valid = d_valid; assign if_ff.clear = d_clear;

  seq_pattern_detector #(.PATTERN_W(W), .PATTERN(8'hB8), .BUZZ_CYCLES(BUZZ), .CNT_W(CW))
    dut_b8 (.clk(clk), .rst_n(rst_n), .bus(if_b8.slave));
  seq_pattern_detector #(.PATTERN_W(W), .PATTERN(8'h00), .BUZZ_CYCLES(BUZZ), .CNT_W(CW))
    dut_00 (.clk(clk), .rst_n(rst_n), .bus(if_00.slave));
  seq_pattern_detector #(.PATTERN_W(W), .PATTERN(8'hAA), .BUZZ_CYCLES(BUZZ), .CNT_W(CW))
    dut_aa (.clk(clk), .rst_n(rst_n), .bus(if_aa.slave));
  seq_pattern_detector #(.PATTERN_W(W), .PATTERN(8'hFF), .BUZZ_CYCLES(BUZZ), .CNT_W(CW))
    dut_ff (.clk(clk), .rst_n(rst_n), .bus(if_ff.slave));

  // Outputs gathered into arrays so the random run can loop over detectors.
  logic          m_o [4];
  logic [CW-1:0] c_o [4];
  logic [W-1:0]  l_o [4];
  logic          b_o [4];
  assign m_o[0] = if_b8.match; assign c_o[0] = if_b8.match_cnt; assign l_o[0] = if_b8.led; assign b_o[0] = if_b8.buzzer;
  assign m_o[1] = if_00.match; assign c_o[1] = if_00.match_cnt; assign l_o[1] = if_00.led; assign b_o[1] = if_00.buzzer;
  assign m_o[2] = if_aa.match; assign c_o[2] = if_aa.match_cnt; assign l_o[2] = if_aa.led; assign b_o[2] = if_aa.buzzer;
  assign m_o[3] = if_ff.match; assign c_o[3] = if_ff.match_cnt; assign l_o[3] = if_ff.led; assign b_o[3] = if_ff.buzzer;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    d_valid = 1'b0; d_bit = 1'b0; d_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle strobe; returns at the negedge after the consuming posedge.
  task automatic strobe(input logic b);
    d_bit = b; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    d_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_bit = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    d_valid = 1'b0; d_bit = 1'b1; d_clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_b8.match !== 1'b0) begin failures++; $display("FAIL reset_match got=%0b exp=0", if_b8.match); end
    checks++; if (if_b8.match_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", if_b8.match_cnt); end
    checks++; if (if_b8.led !== '0) begin failures++; $display("FAIL reset_led got=%0h exp=0", if_b8.led); end
    checks++; if (if_b8.buzzer !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%0b exp=0", if_b8.buzzer); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pattern();
    logic [7:0] pat = 8'hB8;
    int hi;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(pat[7-i]);
      checks++;
      if (if_b8.match !== (i == 7)) begin
        failures++; $display("FAIL t1_match bit%0d got=%0b exp=%0b", i + 1, if_b8.match, (i == 7));
      end
      if (i < 7) idle(9);
    end
    checks++; if (if_b8.match_cnt !== 4'd1) begin failures++; $display("FAIL t1_cnt got=%0d exp=1", if_b8.match_cnt); end
    checks++; if (if_b8.led !== 8'hB8) begin failures++; $display("FAIL t1_led got=%0h exp=b8", if_b8.led); end
    hi = int'(if_b8.buzzer);
    for (int k = 1; k < 30; k++) begin
      idle(1);
      if (k == 1) begin
        checks++; if (if_b8.match !== 1'b0) begin failures++; $display("FAIL t1_pulse_width got=%0b exp=0", if_b8.match); end
      end
      hi += int'(if_b8.buzzer);
    end
    checks++; if (hi != 20) begin failures++; $display("FAIL t1_buzz_len got=%0d exp=20", hi); end
  endtask

  // Follows test_pattern without reset: count is 1, history is full.
  task automatic test_clear();
    logic [4:0] pre = 5'b10111;
    logic [7:0] pat = 8'hB8;
    int nm;
    for (int i = 0; i < 5; i++) begin strobe(pre[4-i]); idle(9); end
    d_clear = 1'b1; d_valid = 1'b1; d_bit = 1'b1;
    @(negedge clk);
    d_clear = 1'b0; d_valid = 1'b0;
    checks++; if (if_b8.led !== '0) begin failures++; $display("FAIL t4_led got=%0h exp=0", if_b8.led); end
    checks++; if (if_b8.match_cnt !== '0) begin failures++; $display("FAIL t4_cnt got=%0d exp=0", if_b8.match_cnt); end
    checks++; if (if_b8.buzzer !== 1'b0) begin failures++; $display("FAIL t4_buzzer got=%0b exp=0", if_b8.buzzer); end
    idle(9);
    // With fill cleared a single zero cannot complete the all-zero pattern.
    strobe(1'b0);
    checks++; if (if_00.match !== 1'b0) begin failures++; $display("FAIL t4_fill got=%0b exp=0", if_00.match); end
    idle(9);
    nm = 0;
    for (int i = 0; i < 8; i++) begin
      strobe(pat[7-i]);
      nm += int'(if_b8.match);
      for (int k = 0; k < 9; k++) begin idle(1); nm += int'(if_b8.match); end
    end
    checks++; if (nm != 1) begin failures++; $display("FAIL t4_matches got=%0d exp=1", nm); end
    checks++; if (if_b8.match_cnt !== 4'd1) begin failures++; $display("FAIL t4_cnt_after got=%0d exp=1", if_b8.match_cnt); end
  endtask

  task automatic test_zero_pattern();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      strobe(1'b0);
      checks++; if (if_00.match !== 1'b0) begin failures++; $display("FAIL t2_early bit%0d got=%0b exp=0", i + 1, if_00.match); end
      idle(9);
    end
    strobe(1'b0);
    checks++; if (if_00.match !== 1'b1) begin failures++; $display("FAIL t2_match got=%0b exp=1", if_00.match); end
    checks++; if (if_00.match_cnt !== 4'd1) begin failures++; $display("FAIL t2_cnt got=%0d exp=1", if_00.match_cnt); end
  endtask

  task automatic test_overlap();
    logic [9:0] bits = 10'b10_1010_1010;
    int hi, rises;
    logic prev, mon;
    hi = 0; rises = 0; prev = 1'b0; mon = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      strobe(bits[9-i]);
      checks++;
      if (if_aa.match !== (i == 7 || i == 9)) begin
        failures++; $display("FAIL t3_match bit%0d got=%0b exp=%0b", i + 1, if_aa.match, (i == 7 || i == 9));
      end
      if (i >= 7) mon = 1'b1;
      if (mon) begin hi += int'(if_aa.buzzer); if (if_aa.buzzer && !prev) rises++; prev = if_aa.buzzer; end
      for (int k = 0; k < ((i == 9) ? 30 : 9); k++) begin
        idle(1);
        if (mon) begin hi += int'(if_aa.buzzer); if (if_aa.buzzer && !prev) rises++; prev = if_aa.buzzer; end
      end
    end
    checks++; if (if_aa.match_cnt !== 4'd2) begin failures++; $display("FAIL t3_cnt got=%0d exp=2", if_aa.match_cnt); end
    checks++; if (hi != 40) begin failures++; $display("FAIL t3_buzz_len got=%0d exp=40", hi); end
    checks++; if (rises != 1) begin failures++; $display("FAIL t3_buzz_rises got=%0d exp=1", rises); end
  endtask

  task automatic test_back_to_back();
    int nm;
    nm = 0;
    do_reset();
    d_bit = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (if_ff.match !== (i >= 7)) begin
        failures++; $display("FAIL t5_match cyc%0d got=%0b exp=%0b", i, if_ff.match, (i >= 7));
      end
      nm += int'(if_ff.match);
    end
    d_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_ff.match !== 1'b0) begin failures++; $display("FAIL t5_tail got=%0b exp=0", if_ff.match); end
    checks++; if (nm != 17) begin failures++; $display("FAIL t5_matches got=%0d exp=17", nm); end
    checks++; if (if_ff.match_cnt !== 4'd15) begin failures++; $display("FAIL t5_cnt got=%0d exp=15", if_ff.match_cnt); end
  endtask

  task automatic test_reset_mid_buzz();
    logic [7:0] pat = 8'hB8;
    int hi;
    do_reset();
    for (int i = 0; i < 8; i++) begin strobe(pat[7-i]); if (i < 7) idle(9); end
    idle(5);
    checks++; if (if_b8.buzzer !== 1'b1) begin failures++; $display("FAIL t6_buzzing got=%0b exp=1", if_b8.buzzer); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (if_b8.buzzer !== 1'b0) begin failures++; $display("FAIL t6_async_buzzer got=%0b exp=0", if_b8.buzzer); end
    checks++; if (if_b8.match_cnt !== '0) begin failures++; $display("FAIL t6_async_cnt got=%0d exp=0", if_b8.match_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 30; k++) begin idle(1); hi += int'(if_b8.buzzer); end
    checks++; if (hi != 0) begin failures++; $display("FAIL t6_no_resume got=%0d exp=0", hi); end
  endtask

  // Reference: queue of bits accepted since reset/clear; a match is the last
  // eight accepted bits equal to the pattern; buzzer is "fewer than BUZZ
  // cycles since the latest match".
  task automatic test_random();
    logic       q[$];
    logic [7:0] pats [4];
    int         nmatch [4];
    int         since [4];
    logic       em [4];
    logic [7:0] hv;
    logic       v, b, c;
    int         ecnt;
    pats[0] = 8'hB8; pats[1] = 8'h00; pats[2] = 8'hAA; pats[3] = 8'hFF;
    for (int p = 0; p < 4; p++) begin nmatch[p] = 0; since[p] = -1; em[p] = 1'b0; end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = ($urandom_range(0, 2) == 0);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 39) == 0);
      d_valid = v; d_bit = b; d_clear = c;
      @(negedge clk);
      if (c) begin
        q.delete();
        for (int p = 0; p < 4; p++) begin nmatch[p] = 0; since[p] = -1; em[p] = 1'b0; end
      end else begin
        if (v) begin
          q.push_back(b);
          if (q.size() > 8) void'(q.pop_front());
        end
        hv = '0;
        foreach (q[k]) hv = {hv[6:0], q[k]};
        for (int p = 0; p < 4; p++) begin
          em[p] = v && (q.size() == 8) && (hv == pats[p]);
          if (em[p]) begin nmatch[p]++; since[p] = 0; end
          else if (since[p] >= 0) since[p]++;
        end
      end
      hv = '0;
      foreach (q[k]) hv = {hv[6:0], q[k]};
      for (int p = 0; p < 4; p++) begin
        ecnt = (nmatch[p] > 15) ? 15 : nmatch[p];
        checks++; if (m_o[p] !== em[p]) begin failures++; $display("FAIL rnd_match det%0d cyc%0d got=%0b exp=%0b", p, cyc, m_o[p], em[p]); end
        checks++; if (c_o[p] !== CW'(ecnt)) begin failures++; $display("FAIL rnd_cnt det%0d cyc%0d got=%0d exp=%0d", p, cyc, c_o[p], ecnt); end
        checks++; if (l_o[p] !== hv) begin failures++; $display("FAIL rnd_led det%0d cyc%0d got=%0h exp=%0h", p, cyc, l_o[p], hv); end
        checks++; if (b_o[p] !== (since[p] >= 0 && since[p] < int'(BUZZ))) begin
          failures++; $display("FAIL rnd_buzzer det%0d cyc%0d got=%0b exp=%0b", p, cyc, b_o[p], (since[p] >= 0 && since[p] < int'(BUZZ)));
        end
      end
    end
    d_valid = 1'b0; d_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_clear();
    test_zero_pattern();
    test_overlap();
    test_back_to_back();
    test_reset_mid_buzz();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_seq_pattern_detector
